// File: rtl/vram_arb_pkg.sv
// Shared types and default widths for the video RAM arbiter.
package vram_arb_pkg;

    localparam int VRAM_ADDR_W  = 13;
    localparam int VRAM_DATA_W  = 8;
    localparam int VRAM_STALL_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_CPU
    } owner_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_ISSUED,
        C_WAIT,
        C_ACK
    } cpu_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle for the arbiter: video fetch, CPU bridge, RAM macro and stats.
// slave = arbiter side, master = the surrounding video/CPU/RAM logic.
interface vram_arbiter_if
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W  = VRAM_ADDR_W,
    parameter int DATA_W  = VRAM_DATA_W,
    parameter int STALL_W = VRAM_STALL_W
);
    logic               vid_req;
    logic [ADDR_W-1:0]  vid_addr;
    logic [DATA_W-1:0]  vid_data;
    logic               vid_valid;

    logic               cpu_req;
    logic               cpu_we;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [DATA_W-1:0]  cpu_wdata;
    logic               cpu_ack;
    logic [DATA_W-1:0]  cpu_rdata;
    logic               cpu_wait;

    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_we;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;

    logic               stat_clr;
    logic [STALL_W-1:0] stall_cnt;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               ram_rdata, stat_clr,
        output vid_data, vid_valid, cpu_ack, cpu_rdata, cpu_wait,
               ram_addr, ram_we, ram_wdata, stall_cnt
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               ram_rdata, stat_clr,
        input  vid_data, vid_valid, cpu_ack, cpu_rdata, cpu_wait,
               ram_addr, ram_we, ram_wdata, stall_cnt
    );
endinterface

// File: rtl/vram_rd_pipe.sv
// Owner-tag pipeline: follows each access through the RAM read latency
// and steers the returned byte to the video or CPU side in c3.
module vram_rd_pipe
    import vram_arb_pkg::*;
#(
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk_pix,
    input  logic              nreset,
    input  owner_t            i_owner,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [DATA_W-1:0] o_vid_data,
    output logic              o_vid_valid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_ack
);
    owner_t            r_tag_c1;
    owner_t            r_tag_c2;
    logic [DATA_W-1:0] r_vid_data;
    logic              r_vid_valid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_cpu_ack;

    always_ff @(posedge clk_pix or negedge nreset) begin
        if (!nreset) begin
            r_tag_c1    <= OWN_NONE;
            r_tag_c2    <= OWN_NONE;
            r_vid_data  <= '0;
            r_vid_valid <= 1'b0;
            r_cpu_rdata <= '0;
            r_cpu_ack   <= 1'b0;
        end else begin
            r_tag_c1    <= i_owner;
            r_tag_c2    <= r_tag_c1;
            r_vid_valid <= (r_tag_c2 == OWN_VID);
            r_cpu_ack   <= (r_tag_c2 == OWN_CPU);
            // ram_rdata belongs to the access tagged two cycles back
            if (r_tag_c2 == OWN_VID) r_vid_data  <= i_ram_rdata;
            if (r_tag_c2 == OWN_CPU) r_cpu_rdata <= i_ram_rdata;
        end
    end

    assign o_vid_data  = r_vid_data;
    assign o_vid_valid = r_vid_valid;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_cpu_ack   = r_cpu_ack;
endmodule

// File: rtl/vram_arbiter.sv
// Video-priority arbiter for the single-port video RAM, fixed 3-cycle latency.
// Optional stall counter built only when VRAM_ARB_STATS_EN is defined.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W  = VRAM_ADDR_W,
    parameter int DATA_W  = VRAM_DATA_W,
    parameter int STALL_W = VRAM_STALL_W
) (
    input logic           clk_pix,
    input logic           nreset,
    vram_arbiter_if.slave bus
);
    cpu_state_t        r_state;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              w_vid_gnt;
    logic              w_cpu_gnt;
    owner_t            w_owner;

    assign w_vid_gnt    = bus.vid_req;
    assign w_cpu_gnt    = !bus.vid_req && bus.cpu_req && (r_state == C_IDLE);
    assign bus.cpu_wait = bus.cpu_req && (r_state == C_IDLE) && bus.vid_req;
    assign w_owner      = w_vid_gnt ? OWN_VID : (w_cpu_gnt ? OWN_CPU : OWN_NONE);

    always_ff @(posedge clk_pix or negedge nreset) begin
        if (!nreset) begin
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_we <= w_cpu_gnt && bus.cpu_we;
            // idle cycles leave the address parked on the last access
            if (w_vid_gnt) begin
                r_ram_addr <= bus.vid_addr;
            end else if (w_cpu_gnt) begin
                r_ram_addr  <= bus.cpu_addr;
                r_ram_wdata <= bus.cpu_wdata;
            end
        end
    end

    // ack coincides with C_ACK; the request is not re-sampled until C_IDLE
    always_ff @(posedge clk_pix or negedge nreset) begin
        if (!nreset) begin
            r_state <= C_IDLE;
        end else begin
            case (r_state)
                C_IDLE:   if (w_cpu_gnt) r_state <= C_ISSUED;
                C_ISSUED: r_state <= C_WAIT;
                C_WAIT:   r_state <= C_ACK;
                default:  r_state <= C_IDLE;
            endcase
        end
    end

    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_wdata = r_ram_wdata;

    vram_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
        .clk_pix     (clk_pix),
        .nreset      (nreset),
        .i_owner     (w_owner),
        .i_ram_rdata (bus.ram_rdata),
        .o_vid_data  (bus.vid_data),
        .o_vid_valid (bus.vid_valid),
        .o_cpu_rdata (bus.cpu_rdata),
        .o_cpu_ack   (bus.cpu_ack)
    );

`ifdef VRAM_ARB_STATS_EN
    logic [STALL_W-1:0] r_stall_cnt;

    always_ff @(posedge clk_pix or negedge nreset) begin
        if (!nreset)
            r_stall_cnt <= '0;
        else if (bus.stat_clr)
            r_stall_cnt <= '0;
        else if (bus.cpu_wait && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    logic w_unused_stat_clr;
    assign w_unused_stat_clr = bus.stat_clr;
    assign bus.stall_cnt     = '0;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural sync RAM.
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int SW = 16;
`ifdef VRAM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk_pix = 1'b0;
    logic nreset  = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .STALL_W(SW)) bus ();

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STALL_W(SW)) dut (
        .clk_pix (clk_pix),
        .nreset  (nreset),
        .bus     (bus)
    );

    always #5 clk_pix = ~clk_pix;

    // background contents until a location is written
    function automatic logic [7:0] pat(input logic [12:0] a);
        return (a == 13'h1800) ? 8'h47 : (a[7:0] ^ {3'b000, a[12:8]});
    endfunction

    logic [7:0] mem     [0:8191];
    bit         wr_mask [0:8191];

    always @(posedge clk_pix) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr]     <= bus.ram_wdata;
            wr_mask[bus.ram_addr] <= 1'b1;
        end
        bus.ram_rdata <= wr_mask[bus.ram_addr] ? mem[bus.ram_addr] : pat(bus.ram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vid"}, {bus.vid_valid, bus.vid_data}, 0);
        chk({tag, "_cpu"}, {bus.cpu_ack, bus.cpu_rdata, bus.cpu_wait}, 0);
        chk({tag, "_ram"}, {bus.ram_we, bus.ram_addr, bus.ram_wdata}, 0);
        chk({tag, "_stall"}, bus.stall_cnt, 0);
    endtask

    initial begin
        int waits;
        int last_ack;
        int acks;
        bit seen;
        bit exp_v;
        logic [12:0] a;

        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.stat_clr  = 1'b0;

        step();
        step();
        chk_all_zero("reset");
        nreset = 1'b1;
        step();

        // single fetch, exact 3-cycle latency
        bus.vid_req  = 1'b1;
        bus.vid_addr = 13'h1800;
        step();
        bus.vid_req = 1'b0;
        chk("fetch_ram_addr", bus.ram_addr, 13'h1800);
        step();
        chk("fetch_early", bus.vid_valid, 0);
        step();
        chk("fetch_valid", bus.vid_valid, 1);
        chk("fetch_data", bus.vid_data, 8'h47);
        step();
        chk("fetch_pulse", bus.vid_valid, 0);

        // contention: video holds the RAM for 4 cycles
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 13'h0100;
        waits = 0;
        for (int i = 0; i < 4; i++) begin
            bus.vid_req  = 1'b1;
            bus.vid_addr = 13'(13'h1000 + i);
            waits += int'(bus.cpu_wait);
            step();
            chk("cont_vaddr", bus.ram_addr, 13'h1000 + i);
        end
        bus.vid_req = 1'b0;
        waits += int'(bus.cpu_wait);
        chk("cont_waits", waits, 4);
        step();
        chk("cont_cpu_addr", {bus.ram_we, bus.ram_addr}, {1'b0, 13'h0100});
        step();
        chk("cont_ack_early", bus.cpu_ack, 0);
        step();
        chk("cont_ack", bus.cpu_ack, 1);
        chk("cont_rdata", bus.cpu_rdata, 8'h01);
        chk("cont_stall", bus.stall_cnt, STATS ? 4 : 0);
        bus.cpu_req = 1'b0;
        step();
        chk("cont_ack_pulse", bus.cpu_ack, 0);

        // CPU write then video read of the same address next cycle
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 13'h0123;
        bus.cpu_wdata = 8'hA5;
        step();
        chk("wr_strobe", {bus.ram_we, bus.ram_addr, bus.ram_wdata}, {1'b1, 13'h0123, 8'hA5});
        bus.vid_req  = 1'b1;
        bus.vid_addr = 13'h0123;
        step();
        bus.vid_req = 1'b0;
        chk("wr_strobe_once", bus.ram_we, 0);
        step();
        chk("wr_ack", bus.cpu_ack, 1);
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        step();
        chk("wr_rd_valid", bus.vid_valid, 1);
        chk("wr_rd_data", bus.vid_data, 8'hA5);
        step();

        // character fetch pattern with a permanently requesting CPU
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 13'h0200;
        last_ack = -1;
        acks = 0;
        for (int cyc = 0; cyc < 51; cyc++) begin
            exp_v = (cyc >= 3) && ((cyc - 3) < 48) &&
                    (((cyc - 3) % 16 == 10) || ((cyc - 3) % 16 == 12));
            chk("pat_vvalid", bus.vid_valid, exp_v);
            if (exp_v) begin
                a = 13'(32'h800 + cyc - 3);
                chk("pat_vdata", bus.vid_data, pat(a));
            end
            if (bus.cpu_ack) begin
                if (last_ack >= 0) chk("pat_ack_gap", (cyc - last_ack) >= 4, 1);
                last_ack = cyc;
                acks++;
            end
            bus.vid_req  = (cyc < 48) && ((cyc % 16 == 10) || (cyc % 16 == 12));
            bus.vid_addr = 13'(32'h800 + cyc);
            step();
        end
        chk("pat_cpu_progress", acks >= 9, 1);
        bus.cpu_req = 1'b0;
        bus.vid_req = 1'b0;
        repeat (4) step();

        // reset while the CPU access is in C_ISSUED and a video read is in flight
        bus.vid_req  = 1'b1;
        bus.vid_addr = 13'h1800;
        step();
        bus.vid_req  = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 13'h0300;
        step();
        nreset = 1'b0;
        #1;
        chk_all_zero("midrst");
        bus.cpu_req = 1'b0;
        step();
        step();
        nreset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= bus.vid_valid | bus.cpu_ack;
            step();
        end
        chk("midrst_no_resp", seen, 0);
        bus.cpu_req = 1'b1;
        bus.vid_req = 1'b1;
        #1;
        chk("midrst_idle", bus.cpu_wait, 1);
        step();
        bus.vid_req = 1'b0;
        step();
        step();
        step();
        chk("midrst_recover_ack", bus.cpu_ack, 1);
        bus.cpu_req = 1'b0;
        step();

        // stall counter: clear priority, count, saturation, clear
        bus.cpu_req  = 1'b1;
        bus.vid_req  = 1'b1;
        bus.stat_clr = 1'b1;
        step();
        chk("stat_clr_prio", bus.stall_cnt, 0);
        bus.stat_clr = 1'b0;
        repeat (10) step();
        chk("stat_count10", bus.stall_cnt, STATS ? 10 : 0);
        repeat (69990) step();
        chk("stat_saturate", bus.stall_cnt, STATS ? 16'hFFFF : 0);
        bus.stat_clr = 1'b1;
        step();
        chk("stat_clr", bus.stall_cnt, 0);
        bus.stat_clr = 1'b0;
        bus.cpu_req  = 1'b0;
        bus.vid_req  = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
